// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Four-channel programmable tick scheduler. Each channel divides
//               the system clock by a runtime-programmable ratio and produces
//               a one-cycle enable pulse (tick) plus a ~50% duty square wave
//               (sq). Downstream logic uses tick as a clock enable.
// Ports       : clk       - system clock, all logic on rising edge
//               rst_n     - synchronous active-low reset
//               run       - level, 1 = count, 0 = hold all counters
//               restart   - one-cycle pulse, zeroes every channel phase
//               cfg_valid - divide-ratio write request
//               cfg_ready - write can be accepted (low during LOAD)
//               cfg_ch    - target channel of the write
//               cfg_div   - new divide ratio (values < 2 store 2)
//               tick      - per-channel one-cycle enable pulse (registered)
//               sq        - per-channel square wave (registered)
// Options     : TICK_SCHED_PHASE_ALIGN_EN - when defined, every config write
//               clears and holds all four channels so they restart
//               phase-aligned; otherwise only the written channel is touched.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DIV0_DEFAULT = 100_000_000,
  parameter int unsigned DIV1_DEFAULT = 50_000_000,
  parameter int unsigned DIV2_DEFAULT = 200_000,
  parameter int unsigned DIV3_DEFAULT = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [3:0]       tick,
  output logic [3:0]       sq
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] load_ch;
  logic       accept;
  logic       count_en;

  // A ratio below 2 cannot produce both a tick and a square wave.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  function automatic logic [CNT_W-1:0] reset_div(input int unsigned ch);
    logic [CNT_W-1:0] d;
    case (ch)
      0:       d = CNT_W'(DIV0_DEFAULT);
      1:       d = CNT_W'(DIV1_DEFAULT);
      2:       d = CNT_W'(DIV2_DEFAULT);
      default: d = CNT_W'(DIV3_DEFAULT);
    endcase
    return clamp_div(d);
  endfunction

  assign cfg_ready = (state != ST_LOAD);
  assign accept    = cfg_valid && cfg_ready;
  // STOP->RUN takes one edge before counting resumes; run=0 holds at once.
  assign count_en  = run && (state != ST_STOP);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      load_ch <= 2'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        load_ch <= cfg_ch;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (accept)   state_nxt = ST_LOAD;
        else if (run) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (accept)    state_nxt = ST_LOAD;
        else if (!run) state_nxt = ST_STOP;
      end
      ST_LOAD: begin
        state_nxt = run ? ST_RUN : ST_STOP;
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-channel divider
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_ch
    localparam logic [CNT_W-1:0] DIV_RST = reset_div(i);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt_nxt;
    logic             write;
    logic             hit;
    logic             held;
    logic             clear;
    logic             wrap;
    logic             tick_q;
    logic             sq_q;

    assign write = accept && (cfg_ch == 2'(i));
`ifdef TICK_SCHED_PHASE_ALIGN_EN
    assign hit   = accept;
    assign held  = (state == ST_LOAD);
`else
    assign hit   = write;
    assign held  = (state == ST_LOAD) && (load_ch == 2'(i));
`endif
    assign clear   = restart || hit || held;
    assign wrap    = (cnt == div - CNT_W'(1));
    assign cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= '0;
        div    <= DIV_RST;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (clear) begin
          cnt  <= '0;
          sq_q <= 1'b0;
        end else if (count_en) begin
          cnt    <= cnt_nxt;
          // Low for the first div>>1 counts, so odd ratios get the longer high.
          sq_q   <= (cnt_nxt >= (div >> 1));
          tick_q <= wrap;
        end
        // A write coinciding with restart still loads the new ratio.
        if (write) begin
          div <= clamp_div(cfg_div);
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule
`default_nettype wire
